quad_step_gen: RTL and testbench



---
 rtl/quad_step_gen_if.sv | 23 ++
 rtl/quad_step_gen.sv | 141 ++++++++++++++
 tb/tb_quad_step_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/quad_step_gen_if.sv
// Encoder-side bundle for quad_step_gen: raw phases/index in, counter strobes out.
// master = encoder/stimulus side, slave = the quad_step_gen front end.
// Pure wiring, no storage.
interface quad_step_gen_if;
  logic qa;
  logic qb;
  logic idx;
  logic clr_err;
  logic step;
  logic dir;
  logic load;
  logic err;

  modport master (
    output qa, qb, idx, clr_err,
    input  step, dir, load, err
  );

  modport slave (
    input  qa, qb, idx, clr_err,
    output step, dir, load, err
  );
endinterface

// File: rtl/quad_step_gen.sv
// Quadrature front end: sync + debounce A/B, decode steps/direction, index load strobe.
// Latency: phase edge to step 3+DEB_CYCLES edges, idx rising to load 3 edges; all outputs registered.
// No backpressure: strobes are single-cycle pulses. Define QUAD_ERR_EN to build illegal-transition err/clr_err.
module quad_step_gen #(
  parameter int DEB_CYCLES = 4  // 1..16
) (
  input  logic           clk,
  input  logic           reset,
  quad_step_gen_if.slave bus
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES - 1);

  // bit2 = idx, bit1 = qa, bit0 = qb, so the low two bits read directly as S = {a, b}
  logic [2:0]      sync1_q, sync1_d;
  logic [2:0]      sync2_q, sync2_d;
  logic [1:0]      filt_q, filt_d;
  logic [1:0]      prev_q, prev_d;
  logic [1:0][3:0] cnt_q, cnt_d;
  logic [1:0]      settle_q, settle_d;
  logic            idx_prev_q, idx_prev_d;
  logic            step_q, step_d;
  logic            dir_q, dir_d;
  logic            load_q, load_d;
  logic            settled;

`ifdef QUAD_ERR_EN
  logic            err_q, err_d;
`else
  logic            unused_clr_err;
  assign unused_clr_err = bus.clr_err;
`endif

  // Three edges after reset release the synchronisers hold real input levels
  assign settled = (settle_q == 2'd3);

  // Synchronisers, settle window and per-phase debounce
  always_comb begin
    sync1_d    = {bus.idx, bus.qa, bus.qb};
    sync2_d    = sync1_q;
    idx_prev_d = sync2_q[2];
    filt_d     = filt_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    prev_d     = filt_q;
    if (!settled) begin
      // Adopt whatever the encoder sits at; P follows so no step is seen on exit
      settle_d = settle_q + 2'd1;
      filt_d   = sync2_q[1:0];
      prev_d   = sync2_q[1:0];
      cnt_d    = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DEB_MAX) begin
          filt_d[i] = sync2_q[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Gray-code decode of P -> S, index edge detect, sticky error
  always_comb begin
    step_d = 1'b0;
    dir_d  = dir_q;
    load_d = 1'b0;
`ifdef QUAD_ERR_EN
    err_d  = err_q;
    // clear first so a simultaneous illegal transition re-sets it
    if (bus.clr_err) err_d = 1'b0;
`endif
    if (settled) begin
      load_d = sync2_q[2] & ~idx_prev_q;
      case ({prev_q, filt_q})
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
          step_d = 1'b1;
          dir_d  = 1'b1;
        end
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
          step_d = 1'b1;
          dir_d  = 1'b0;
        end
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
          // both phases moved in one sample: direction unknown, count nothing
`ifdef QUAD_ERR_EN
          err_d = 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      settle_q   <= '0;
      idx_prev_q <= 1'b0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      idx_prev_q <= idx_prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      load_q     <= load_d;
    end
  end

`ifdef QUAD_ERR_EN
  // Sticky illegal-transition flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.step = step_q;
  assign bus.dir  = dir_q;
  assign bus.load = load_q;

endmodule

// File: tb/tb_quad_step_gen.sv
// Directed bench for quad_step_gen: expected step/load cycles queued at drive time,
// popped and compared when the strobes appear. err expectations follow QUAD_ERR_EN.
// Inputs driven and outputs sampled on the falling edge.
module tb_quad_step_gen;
  localparam int DEB     = 4;
  localparam int LAT     = 3 + DEB;  // phase change to step
  localparam int IDX_LAT = 3;        // idx rise to load
`ifdef QUAD_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct {
    int   cyc;
    logic dir;
  } step_exp_t;

  logic      clk;
  logic      rst_n;
  step_exp_t step_q[$];
  int        load_q[$];
  int        cyc;
  int        checks;
  int        failures;

  quad_step_gen_if bus();

  quad_step_gen #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; on the falling edge retire any step/load strobes against the queues
  task automatic tick();
    step_exp_t e;
    int        l;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (bus.step === 1'b1) begin
        if (step_q.size() == 0) begin
          check("step_unexpected", 32'(bus.step), 32'd0);
        end else begin
          e = step_q.pop_front();
          check("step_cycle", cyc, e.cyc);
          check("step_dir", 32'(bus.dir), 32'(e.dir));
        end
      end
      if (step_q.size() > 0 && step_q[0].cyc < cyc) begin
        e = step_q.pop_front();
        check("step_missing", cyc, e.cyc);
      end
      if (bus.load === 1'b1) begin
        if (load_q.size() == 0) begin
          check("load_unexpected", 32'(bus.load), 32'd0);
        end else begin
          l = load_q.pop_front();
          check("load_cycle", cyc, l);
        end
      end
      if (load_q.size() > 0 && load_q[0] < cyc) begin
        l = load_q.pop_front();
        check("load_missing", cyc, l);
      end
    end
  endtask

  task automatic drive_ab(input logic a, input logic b, input logic exp_step,
                          input logic exp_dir, input int hold);
    step_exp_t e;
    bus.qa = a;
    bus.qb = b;
    if (exp_step) begin
      e.cyc = cyc + LAT;
      e.dir = exp_dir;
      step_q.push_back(e);
    end
    repeat (hold) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_step"}, 32'(bus.step), 32'd0);
    check({tag, "_dir"},  32'(bus.dir),  32'd0);
    check({tag, "_load"}, 32'(bus.load), 32'd0);
    check({tag, "_err"},  32'(bus.err),  32'd0);
  endtask

  initial begin
    cyc         = 0;
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    bus.qa      = 1'b1;
    bus.qb      = 1'b1;
    bus.idx     = 1'b0;
    bus.clr_err = 1'b0;

    // Reset with encoder parked at 11
    repeat (3) tick();
    check_reset_outputs("reset");
    check("reset_prev", 32'(dut.prev_q), 32'd0);

    // Release: settle adopts 11 silently
    rst_n = 1'b1;
    repeat (10) tick();
    check("settle_err", 32'(bus.err), 32'd0);
    check("settle_prev", 32'(dut.prev_q), 32'h3);

    // Walk down to 00
    drive_ab(1'b0, 1'b1, 1'b1, 1'b0, 20);
    drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 20);

    // Forward 00->01->11->10->00
    drive_ab(1'b0, 1'b1, 1'b1, 1'b1, 20);
    drive_ab(1'b1, 1'b1, 1'b1, 1'b1, 20);
    drive_ab(1'b1, 1'b0, 1'b1, 1'b1, 20);
    drive_ab(1'b0, 1'b0, 1'b1, 1'b1, 20);
    check("dir_after_up", 32'(bus.dir), 32'd1);

    // Reverse 00->10->11->01->00
    drive_ab(1'b1, 1'b0, 1'b1, 1'b0, 20);
    drive_ab(1'b1, 1'b1, 1'b1, 1'b0, 20);
    drive_ab(1'b0, 1'b1, 1'b1, 1'b0, 20);
    drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 20);
    check("dir_after_down", 32'(bus.dir), 32'd0);

    // Reversal mid-sequence 00->01->11->01->00
    drive_ab(1'b0, 1'b1, 1'b1, 1'b1, 20);
    drive_ab(1'b1, 1'b1, 1'b1, 1'b1, 20);
    drive_ab(1'b0, 1'b1, 1'b1, 1'b0, 20);
    drive_ab(1'b0, 1'b0, 1'b1, 1'b0, 20);

    // 3-cycle glitch on qa is filtered
    drive_ab(1'b1, 1'b0, 1'b0, 1'b0, 3);
    drive_ab(1'b0, 1'b0, 1'b0, 1'b0, 20);
    check("glitch3_filt", 32'(dut.filt_q), 32'd0);

    // 4-cycle pulse passes: 00->10 (down), and its trailing edge 10->00 (up)
    drive_ab(1'b1, 1'b0, 1'b1, 1'b0, 4);
    drive_ab(1'b0, 1'b0, 1'b1, 1'b1, 20);
    check("dir_after_pulse", 32'(bus.dir), 32'd1);

    // Illegal 00->11: no step, sticky err, dir holds
    drive_ab(1'b1, 1'b1, 1'b0, 1'b0, 20);
    check("err_set", 32'(bus.err), 32'(ERR_EN));
    check("dir_hold_illegal", 32'(bus.dir), 32'd1);
    repeat (10) tick();
    check("err_sticky", 32'(bus.err), 32'(ERR_EN));
    bus.clr_err = 1'b1;
    tick();
    check("err_clr", 32'(bus.err), 32'd0);
    bus.clr_err = 1'b0;
    tick();
    check("err_stays_clr", 32'(bus.err), 32'd0);

    // Illegal 11->00 with clr_err held across the setting edge: set wins
    drive_ab(1'b0, 1'b0, 1'b0, 1'b0, LAT - 1);
    bus.clr_err = 1'b1;
    tick();
    check("err_set_wins", 32'(bus.err), 32'(ERR_EN));
    bus.clr_err = 1'b0;
    repeat (10) tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    check("err_clr2", 32'(bus.err), 32'd0);

    // idx rising lands on the same cycle as a 00->01 step; held high gives one load
    drive_ab(1'b0, 1'b1, 1'b1, 1'b1, 4);
    bus.idx = 1'b1;
    load_q.push_back(cyc + IDX_LAT);
    repeat (50) tick();
    bus.idx = 1'b0;
    repeat (10) tick();

    // Lone idx pulse
    bus.idx = 1'b1;
    load_q.push_back(cyc + IDX_LAT);
    repeat (10) tick();
    bus.idx = 1'b0;
    repeat (5) tick();

    // Reset mid-step: pending pulse lost, outputs cleared, settles at 11
    drive_ab(1'b1, 1'b1, 1'b0, 1'b0, 3);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    repeat (20) tick();
    check("midreset_prev", 32'(dut.prev_q), 32'h3);

    check("step_queue_drained", step_q.size(), 32'd0);
    check("load_queue_drained", load_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
